intc_vec: RTL

- Parametrised, vectored interrupt controller for the MIPS SoC. It replaces the fixed 4-source controller and supports NUM_SRC accelerator done lines.
- Edge-detects source done pulses into pending bits and applies a software mask.
- Arbitrates by fixed or round-robin priority, then drives IRQ/IACK and a per-source ISR vector into the MIPS core.
- Software access is a memory-mapped register window, decoded by the memory map like any other device.

---
 rtl/intc_pkg.sv | 23 ++
 rtl/intc_arbiter.sv | 37 +++
 rtl/intc_vec.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the vectored interrupt controller: register
// offsets within the 4-word window, handshake FSM states and the id width helper.
package intc_pkg;

    // Word offsets selected by input_addr[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_CLEAR  = 2'd2;
    localparam logic [1:0] REG_ACTIVE = 2'd3;

    // Handshake with the MIPS core: idle, request outstanding, waiting for iack release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Width of a source id; never zero so a single-source build still has a legal vector
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Combinational winner selection over the eligible (pending & mask) set.
// Fixed mode picks the lowest index; round-robin starts the search just
// after the last serviced source and wraps around.
module intc_arbiter
    import intc_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int RR_MODE = 0,
    localparam int IDW     = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [IDW-1:0]     last_id,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_valid
);

    // Scan from the start index and take the first eligible source
    always_comb begin
        int start_idx;
        int idx;
        start_idx   = 0;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (RR_MODE != 0) begin
            start_idx = (int'(last_id) + 1) % NUM_SRC;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (start_idx + k) % NUM_SRC;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/intc_vec.sv
// Vectored interrupt controller for the MIPS SoC. Rising edges on the done
// lines set pending bits; masked-in pending sources are arbitrated and the
// winner is presented on irq/isr_addr until the core acknowledges it.
module intc_vec
    import intc_pkg::*;
#(
    parameter int                 NUM_SRC    = 4,
    parameter logic [31:0]        ISR_BASE   = 32'h0000_0000,
    parameter logic [31:0]        ISR_STRIDE = 32'h0000_0010,
    parameter int                 RR_MODE    = 0,
    parameter logic [NUM_SRC-1:0] MASK_RST   = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] done,
    output logic               irq,
    input  logic               iack,
    output logic [31:0]        isr_addr,
    input  logic [31:0]        input_addr,
    input  logic               write_enable,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data
);

    localparam int IDW = id_width(NUM_SRC);

    state_t               state_reg, state_next;
    logic [NUM_SRC-1:0]   done_q_reg;
    logic [NUM_SRC-1:0]   pending_reg, pending_next;
    logic [NUM_SRC-1:0]   mask_reg;
    logic [IDW-1:0]       cur_id_reg;
    logic [IDW-1:0]       last_id_reg;
    logic [31:0]          isr_addr_reg;

    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   sw_clr;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [1:0]           reg_sel;
    logic                 wr_mask;
    logic                 wr_clear;
    logic                 take_req;
    logic                 take_ack;
    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;
    logic                 unused_bits;

    // Only the word select is decoded; the rest of the address and the
    // write data above NUM_SRC are deliberately ignored.
    assign reg_sel     = input_addr[3:2];
    assign unused_bits = ^{input_addr[31:4], input_addr[1:0], write_data};

    assign wr_mask  = write_enable && (reg_sel == REG_MASK);
    assign wr_clear = write_enable && (reg_sel == REG_CLEAR);

    assign rise     = done & ~done_q_reg;
    assign eligible = pending_reg & mask_reg;

    // Per-source pending update: software clear and ACK auto-clear, with a
    // coincident rising edge taking precedence over either clear.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
            assign sw_clr[gi]       = wr_clear & write_data[gi];
            assign ack_clr[gi]      = take_ack && (cur_id_reg == IDW'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~(sw_clr[gi] | ack_clr[gi])) | rise[gi];
        end
    endgenerate

    intc_arbiter #(
        .NUM_SRC (NUM_SRC),
        .RR_MODE (RR_MODE)
    ) u_arbiter (
        .eligible    (eligible),
        .last_id     (last_id_reg),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Edge-detect history, pending and mask registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q_reg  <= '0;
            pending_reg <= '0;
            mask_reg    <= MASK_RST;
        end else begin
            done_q_reg  <= done;
            pending_reg <= pending_next;
            if (wr_mask) begin
                mask_reg <= write_data[NUM_SRC-1:0];
            end
        end
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake next-state: commit a winner, wait for iack, wait for its release
    always_comb begin
        state_next = state_reg;
        take_req   = 1'b0;
        take_ack   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    take_req   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (iack) begin
                    take_ack   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!iack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // In-service id and vector latched on commit; last_id feeds round-robin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_id_reg   <= '0;
            last_id_reg  <= IDW'(NUM_SRC - 1);
            isr_addr_reg <= '0;
        end else begin
            if (take_req) begin
                cur_id_reg   <= grant_id;
                isr_addr_reg <= ISR_BASE + (32'(grant_id) * ISR_STRIDE);
            end
            if (take_ack) begin
                last_id_reg <= cur_id_reg;
            end
        end
    end

    assign irq      = (state_reg == REQ);
    assign isr_addr = isr_addr_reg;

    // Register read mux; unimplemented high bits read as zero
    always_comb begin
        read_data = '0;
        case (reg_sel)
            REG_STATUS: read_data = 32'(pending_reg);
            REG_MASK:   read_data = 32'(mask_reg);
            REG_CLEAR:  read_data = '0;
            REG_ACTIVE: begin
                read_data[31]      = (state_reg != IDLE);
                read_data[IDW-1:0] = cur_id_reg;
            end
            default:    read_data = '0;
        endcase
    end

endmodule
